// File: rtl/ir_predecode.sv
// Opcode-fetch stage feeding timing_ctrl: latches the instruction register at T1, predecodes
// one/two-cycle opcodes, and sequences RESET/NMI/IRQ by injecting BRK (8'h00) into IR.
module ir_predecode #(
    parameter bit         CMOS     = 1'b1,
    parameter logic [7:0] IR_RESET = 8'hEA
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ready,
    input  logic [2:0] t,
    input  logic [7:0] data_in,
    input  logic       i_flag,
    input  logic       irq_n,
    input  logic       nmi_n,
    output logic [7:0] ir,
    output logic       onecycle,
    output logic       twocycle,
    output logic       int_active,
    output logic [1:0] vec_sel,
    output logic       pc_hold
);

    typedef enum logic [1:0] {
        VEC_IRQ = 2'b00,
        VEC_NMI = 2'b01,
        VEC_RST = 2'b10
    } vec_e;

    localparam logic [2:0] T1 = 3'd1;

    logic nmi_s1;
    logic nmi_s2;
    logic nmi_prev;
    logic nmi_edge;
    logic nmi_pend;
    logic rst_pend;
    logic irq_take;
    logic fetch;
    logic fetch_en;
    logic inject;
    logic take_int;
    vec_e src;

    logic [7:0] op;
    logic       is_imm;
    logic       is_impl;
    logic       is_stack_flow;
    logic       is_ld_cmp_imm;
    logic       one_raw;
    logic       two_raw;

    // NMI is asynchronous: two-flop synchroniser plus a history flop for the falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_s1   <= 1'b0;
            nmi_s2   <= 1'b0;
            nmi_prev <= 1'b0;
        end else begin
            nmi_s1   <= nmi_n;
            nmi_s2   <= nmi_s1;
            nmi_prev <= nmi_s2;
        end
    end

    assign nmi_edge = nmi_prev & ~nmi_s2;
    assign irq_take = ~irq_n & ~i_flag;
    assign fetch    = (t == T1);
    assign fetch_en = ready & fetch;
    assign inject   = fetch & (rst_pend | nmi_pend | irq_take);
    assign take_int = fetch_en & inject;
    assign pc_hold  = inject;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        src = VEC_IRQ;
        if (rst_pend) begin
            src = VEC_RST;
        end else if (nmi_pend) begin
            src = VEC_NMI;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir         <= IR_RESET;
            int_active <= 1'b0;
            vec_sel    <= VEC_IRQ;
            rst_pend   <= 1'b1;
            nmi_pend   <= 1'b0;
        end else begin
            if (fetch_en) begin
                if (inject) begin
                    ir         <= 8'h00;
                    int_active <= 1'b1;
                    vec_sel    <= src;
                end else begin
                    ir         <= data_in;
                    int_active <= 1'b0;
                    vec_sel    <= VEC_IRQ;
                end
            end

            if (take_int && rst_pend) begin
                rst_pend <= 1'b0;
            end

            // A fresh edge in the consuming cycle keeps the NMI pending.
            if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end else if (take_int && !rst_pend && nmi_pend) begin
                nmi_pend <= 1'b0;
            end
        end
    end

    assign op            = data_in;
    assign is_imm        = ((op & 8'h1F) == 8'h09);
    assign is_stack_flow = (op inside {8'h08, 8'h28, 8'h48, 8'h68, 8'h00, 8'h40, 8'h60});
    assign is_impl       = (((op & 8'h0F) == 8'h08) || ((op & 8'h0F) == 8'h0A)) && !is_stack_flow;
    assign is_ld_cmp_imm = (op inside {8'hA0, 8'hA2, 8'hC0, 8'hE0});
    assign one_raw       = CMOS && ((op & 8'h07) == 8'h03);
    assign two_raw       = !one_raw && (is_imm || is_impl || is_ld_cmp_imm);

    assign onecycle = fetch & ~inject & one_raw;
    assign twocycle = fetch & ~inject & two_raw;

endmodule
